// File: rtl/lsu_align_if.sv
// Request/response and data-memory bus bundle for lsu_align.
// slave = the alignment unit, master = the requester/memory side.
interface lsu_align_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_fault;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [1:0]            mem_wsel;
    logic [2:0]            mem_rsel;
    logic                  mem_rw;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_wdata, mem_wsel, mem_rsel, mem_rw
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_wdata, mem_wsel, mem_rsel, mem_rw
    );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit: word-only memory traffic, RMW for sub-word stores, split crossing accesses.
// Optional LSU_MISALIGN_TRAP_EN: fault any non-naturally-aligned access instead of splitting it.
module lsu_align #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    lsu_align_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD0, RD1, MRG, WR0, WR1, RESP} state_t;

    state_t                state_q;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] w0_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [DATA_WIDTH-1:0] wd1_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  mem_rw_q;
    logic                  resp_valid_q;
    logic                  resp_fault_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

    logic [2:0]            req_f3;
    logic [1:0]            req_off;
    logic [ADDR_WIDTH-1:0] req_w0;
    logic                  req_illegal;
    logic                  req_misal;
    logic                  req_word_store;

    assign req_f3         = bus.req_funct3;
    assign req_off        = bus.req_addr[1:0];
    assign req_w0         = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign req_illegal    = bus.req_we ? (req_f3[2] || req_f3 == 3'b011)
                                       : (req_f3 == 3'b011 || req_f3[2:1] == 2'b11);
    assign req_word_store = bus.req_we && req_f3 == 3'b010 && req_off == 2'b00;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misal = (req_f3[1:0] == 2'b01 && req_off[0]) ||
                       (req_f3[1:0] == 2'b10 && req_off != 2'b00);
`else
    assign req_misal = 1'b0;
`endif

    logic [3:0]            size_w;
    logic [3:0]            end_w;
    logic                  cross_w;
    logic [ADDR_WIDTH-1:0] w1_w;

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   size_w = 4'd1;
            2'b01:   size_w = 4'd2;
            default: size_w = 4'd4;
        endcase
    end

    assign end_w   = {2'b00, off_q} + size_w;
    assign cross_w = end_w > 4'd4;
    assign w1_w    = w0_q + ADDR_WIDTH'(4);

    // {hi, lo} as one little-endian 8-byte window; MRG sees the last read word on mem_rdata.
    logic [DATA_WIDTH-1:0]   mrg_lo_w;
    logic [DATA_WIDTH-1:0]   mrg_hi_w;
    logic [2*DATA_WIDTH-1:0] span_w;
    logic [2*DATA_WIDTH-1:0] wsh_w;
    logic [2*DATA_WIDTH-1:0] merged_w;
    logic [7:0]              be_w;
    logic [DATA_WIDTH-1:0]   ld_word_w;
    logic [DATA_WIDTH-1:0]   ld_ext_w;

    assign mrg_lo_w = cross_w ? lo_q : bus.mem_rdata;
    assign mrg_hi_w = cross_w ? bus.mem_rdata : '0;
    assign span_w   = {mrg_hi_w, mrg_lo_w};
    assign wsh_w    = {{DATA_WIDTH{1'b0}}, wdata_q} << {off_q, 3'b000};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte
            assign be_w[gi] = (4'(gi) >= {2'b00, off_q}) && (4'(gi) < end_w);
            assign merged_w[gi*8 +: 8] = be_w[gi] ? wsh_w[gi*8 +: 8] : span_w[gi*8 +: 8];
        end
    endgenerate

    assign ld_word_w = DATA_WIDTH'(span_w >> {off_q, 3'b000});

    always_comb begin
        case (funct3_q)
            3'b000:  ld_ext_w = {{24{ld_word_w[7]}}, ld_word_w[7:0]};
            3'b001:  ld_ext_w = {{16{ld_word_w[15]}}, ld_word_w[15:0]};
            3'b100:  ld_ext_w = {24'b0, ld_word_w[7:0]};
            3'b101:  ld_ext_w = {16'b0, ld_word_w[15:0]};
            default: ld_ext_w = ld_word_w;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            w0_q         <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            wd1_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rw_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            mem_rw_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        funct3_q <= req_f3;
                        off_q    <= req_off;
                        w0_q     <= req_w0;
                        wdata_q  <= bus.req_wdata;
                        if (req_illegal || req_misal) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (req_word_store) begin
                            state_q     <= WR0;
                            mem_addr_q  <= req_w0;
                            mem_rw_q    <= 1'b1;
                            mem_wdata_q <= bus.req_wdata;
                        end else begin
                            state_q    <= RD0;
                            mem_addr_q <= req_w0;
                        end
                    end
                end
                RD0: begin
                    if (cross_w) begin
                        state_q    <= RD1;
                        mem_addr_q <= w1_w;
                    end else begin
                        state_q <= MRG;
                    end
                end
                RD1: begin
                    lo_q    <= bus.mem_rdata;
                    state_q <= MRG;
                end
                MRG: begin
                    lo_q <= mrg_lo_w;
                    if (we_q) begin
                        state_q     <= WR0;
                        mem_addr_q  <= w0_q;
                        mem_rw_q    <= 1'b1;
                        mem_wdata_q <= merged_w[DATA_WIDTH-1:0];
                        wd1_q       <= merged_w[2*DATA_WIDTH-1:DATA_WIDTH];
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b0;
                        resp_rdata_q <= ld_ext_w;
                    end
                end
                WR0: begin
                    if (cross_w) begin
                        state_q     <= WR1;
                        mem_addr_q  <= w1_w;
                        mem_rw_q    <= 1'b1;
                        mem_wdata_q <= wd1_q;
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end
                WR1: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= '0;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A write already presented must not land on the edge that reset is sampled.
    assign bus.mem_rw     = mem_rw_q & ~rst;
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wsel   = 2'b00;
    assign bus.mem_rsel   = 3'b000;
endmodule

// File: tb/tb_lsu_align.sv
// Directed self-checking bench for lsu_align with a word-addressed memory model.
module tb_lsu_align;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_align_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    lsu_align #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // memory model: index = addr[11:2], registered read, write when mem_rw
    logic [31:0] mem [0:1023];
    logic [31:0] wr_addr_log [0:63];
    logic [31:0] wr_data_log [0:63];
    int          wr_cnt  = 0;
    int          sel_bad = 0;
    logic        pl_en   = 1'b0;
    logic [31:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr[11:2]] <= pl_data;
        end else if (bus_if.mem_rw) begin
            mem[bus_if.mem_addr[11:2]] <= bus_if.mem_wdata;
            wr_addr_log[wr_cnt % 64]   <= bus_if.mem_addr;
            wr_data_log[wr_cnt % 64]   <= bus_if.mem_wdata;
            wr_cnt                     <= wr_cnt + 1;
        end
        if (!bus_if.mem_rw)
            bus_if.mem_rdata <= mem[bus_if.mem_addr[11:2]];
        if (bus_if.mem_rsel != 3'b000 || bus_if.mem_wsel != 2'b00)
            sel_bad <= sel_bad + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int exp_lat, input logic [31:0] exp_rd, input logic exp_flt,
                       input int exp_nwr, output int base);
        int          lat;
        logic [31:0] rd;
        logic        flt;
        @(negedge clk);
        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = we;
        bus_if.req_funct3 = f3;
        bus_if.req_addr   = addr;
        bus_if.req_wdata  = wd;
        base = wr_cnt;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        lat = 0;
        rd  = '0;
        flt = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus_if.resp_valid) begin
                lat = n;
                rd  = bus_if.resp_rdata;
                flt = bus_if.resp_fault;
                check_eq({tag, "/ready_in_resp"}, 32'(bus_if.req_ready), 32'd0);
                break;
            end
        end
        check_eq({tag, "/latency"}, lat, exp_lat);
        check_eq({tag, "/rdata"}, rd, exp_rd);
        check_eq({tag, "/fault"}, 32'(flt), 32'(exp_flt));
        @(negedge clk);
        check_eq({tag, "/pulse_end"}, 32'(bus_if.resp_valid), 32'd0);
        check_eq({tag, "/ready_after"}, 32'(bus_if.req_ready), 32'd1);
        check_eq({tag, "/writes"}, wr_cnt - base, exp_nwr);
        $display("txn %-10s we=%0b f3=%03b addr=%08h wdata=%08h lat=%0d rdata=%08h fault=%0b writes=%0d",
                 tag, we, f3, addr, wd, lat, rd, flt, wr_cnt - base);
    endtask

    initial begin
        int   b;
        int   seen;
        int   resp_seen;
        bus_if.req_valid  = 1'b0;
        bus_if.req_we     = 1'b0;
        bus_if.req_funct3 = 3'b000;
        bus_if.req_addr   = '0;
        bus_if.req_wdata  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset/req_ready", 32'(bus_if.req_ready), 32'd1);
        check_eq("reset/resp_valid", 32'(bus_if.resp_valid), 32'd0);
        check_eq("reset/resp_fault", 32'(bus_if.resp_fault), 32'd0);
        check_eq("reset/resp_rdata", bus_if.resp_rdata, 32'd0);
        check_eq("reset/mem_rw", 32'(bus_if.mem_rw), 32'd0);
        check_eq("reset/mem_addr", bus_if.mem_addr, 32'd0);
        check_eq("reset/mem_wdata", bus_if.mem_wdata, 32'd0);

        preload(32'h0000_0100, 32'h8899_AABB);
        preload(32'h0000_0200, 32'h4433_2211);
        preload(32'h0000_0204, 32'h8877_6655);
        preload(32'hFFFF_FFFC, 32'h1122_3344);
        preload(32'h0000_0000, 32'h5566_7788);
        preload(32'h0000_01FC, 32'h0000_0000);
        preload(32'h0000_0300, 32'h0000_0000);

        run("lb_101",  1'b0, 3'b000, 32'h101, 32'h0, 3, 32'hFFFF_FFAA, 1'b0, 0, b);
        run("lbu_101", 1'b0, 3'b100, 32'h101, 32'h0, 3, 32'h0000_00AA, 1'b0, 0, b);

        run("sb_102",  1'b1, 3'b000, 32'h102, 32'h5C, 4, 32'h0, 1'b0, 1, b);
        check_eq("sb_102/wr_addr", wr_addr_log[b % 64], 32'h100);
        check_eq("sb_102/wr_data", wr_data_log[b % 64], 32'h885C_AABB);
        check_eq("sb_102/mem", mem[10'h040], 32'h885C_AABB);

        run("lh_102",  1'b0, 3'b001, 32'h102, 32'h0, 3, 32'hFFFF_885C, 1'b0, 0, b);
        run("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 3, 32'h0000_885C, 1'b0, 0, b);

`ifdef LSU_MISALIGN_TRAP_EN
        run("lw_203",  1'b0, 3'b010, 32'h203, 32'h0, 1, 32'h0, 1'b1, 0, b);
`else
        run("lw_203",  1'b0, 3'b010, 32'h203, 32'h0, 4, 32'h7766_5544, 1'b0, 0, b);
`endif

        preload(32'h0000_0200, 32'h0000_0000);
`ifdef LSU_MISALIGN_TRAP_EN
        run("sh_1ff",  1'b1, 3'b001, 32'h1FF, 32'hBEEF, 1, 32'h0, 1'b1, 0, b);
        check_eq("sh_1ff/mem_w0", mem[10'h07F], 32'h0);
        run("lh_1ff",  1'b0, 3'b001, 32'h1FF, 32'h0, 1, 32'h0, 1'b1, 0, b);
        run("lw_wrap", 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 1, 32'h0, 1'b1, 0, b);
`else
        run("sh_1ff",  1'b1, 3'b001, 32'h1FF, 32'hBEEF, 6, 32'h0, 1'b0, 2, b);
        check_eq("sh_1ff/wr0_addr", wr_addr_log[b % 64], 32'h1FC);
        check_eq("sh_1ff/wr0_data", wr_data_log[b % 64], 32'hEF00_0000);
        check_eq("sh_1ff/wr1_addr", wr_addr_log[(b + 1) % 64], 32'h200);
        check_eq("sh_1ff/wr1_data", wr_data_log[(b + 1) % 64], 32'h0000_00BE);
        run("lh_1ff",  1'b0, 3'b001, 32'h1FF, 32'h0, 4, 32'hFFFF_BEEF, 1'b0, 0, b);
        run("lw_wrap", 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 4, 32'h7788_1122, 1'b0, 0, b);
`endif

        run("sw_300",  1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 2, 32'h0, 1'b0, 1, b);
        check_eq("sw_300/wr_addr", wr_addr_log[b % 64], 32'h300);
        check_eq("sw_300/wr_data", wr_data_log[b % 64], 32'hCAFE_F00D);
        run("lw_300",  1'b0, 3'b010, 32'h300, 32'h0, 3, 32'hCAFE_F00D, 1'b0, 0, b);
        run("ld_f3_011", 1'b0, 3'b011, 32'h300, 32'h0, 1, 32'h0, 1'b1, 0, b);
        run("st_f3_100", 1'b1, 3'b100, 32'h300, 32'h1, 1, 32'h0, 1'b1, 0, b);
        check_eq("st_f3_100/mem", mem[10'h0C0], 32'hCAFE_F00D);
        check_eq("sel_tied", sel_bad, 0);

        // reset while the first write of a store is on the bus
        @(negedge clk);
        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = 1'b1;
        bus_if.req_funct3 = 3'b001;
`ifdef LSU_MISALIGN_TRAP_EN
        bus_if.req_addr   = 32'h1FE;
`else
        bus_if.req_addr   = 32'h1FF;
`endif
        bus_if.req_wdata  = 32'h1234;
        b = wr_cnt;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        seen = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus_if.mem_rw) begin
                seen = 1;
                break;
            end
        end
        check_eq("rst/wr0_reached", seen, 1);
        rst = 1'b1;
        #1;
        check_eq("rst/mem_rw_forced", 32'(bus_if.mem_rw), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst/ready", 32'(bus_if.req_ready), 32'd1);
        resp_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_if.resp_valid) resp_seen = 1;
        end
        check_eq("rst/no_resp", resp_seen, 0);
        check_eq("rst/no_write", wr_cnt - b, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("rst/w0_kept", mem[10'h07F], 32'h0);
        check_eq("rst/w1_kept", mem[10'h080], 32'h0);
`else
        check_eq("rst/w0_kept", mem[10'h07F], 32'hEF00_0000);
        check_eq("rst/w1_kept", mem[10'h080], 32'h0000_00BE);
`endif
        $display("txn %-10s reset during WR0 writes=%0d", "rst_mid", wr_cnt - b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit that sits directly upstream of the data memory.
- Accepts one RISC-V load/store (funct3-encoded size and sign) per handshake, at any byte address.
- Issues only word-aligned word reads and writes to the memory (mem_rsel=000, mem_wsel=00). Sub-word stores use read-modify-write; word-crossing accesses are split into two word accesses.
- Returns sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 32, width of request and memory address.
- DATA_WIDTH, 32, data width. The block is only defined for 32.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu (stores: 000/001/010 only)
- req_addr  in  ADDR_WIDTH  byte address, any alignment
- req_wdata  in  DATA_WIDTH  store data, low bytes significant
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  DATA_WIDTH  extended load data, valid with resp_valid (0 for stores)
- resp_fault  out  1  access rejected, valid with resp_valid
- mem_addr  out  ADDR_WIDTH  word address to memory, bits [1:0] always 00
- mem_wdata  out  DATA_WIDTH  merged word to write
- mem_wsel  out  2  tied 00
- mem_rsel  out  3  tied 000
- mem_rw  out  1  1 = write this cycle, 0 = read
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read address is presented

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state = IDLE; req_ready = 1 after reset.
  - resp_valid = 0, resp_fault = 0, resp_rdata = 0.
  - mem_rw = 0, mem_addr = 0, mem_wdata = 0.
  - mem_rw is forced 0 in any cycle where rst = 1.
- Reset mid-operation: the access is abandoned and no response is given. Writes issued at earlier edges persist; no further writes occur.
- Handshake and request latch:
  - Accept when req_valid && req_ready at a rising edge.
  - On accept, latch we, funct3, addr, wdata.
  - size = 1/2/4 bytes; off = addr[1:0]; cross = off + size > 4.
  - w0 = {addr[31:2], 00}; w1 = w0 + 4, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- States: IDLE, RD0, RD1, MRG, WR0, WR1, RESP.
  - IDLE: req_ready = 1.
    - Aligned word store → WR0.
    - Illegal funct3 (load 011/110/111, store 1xx/011) → RESP with resp_fault = 1 and no memory access.
    - Otherwise → RD0.
  - RD0: mem_addr = w0, mem_rw = 0. → RD1 if cross, else MRG.
  - RD1: mem_addr = w1, mem_rw = 0. Capture mem_rdata into lo (word0). → MRG.
  - MRG: capture mem_rdata into hi if cross, else into lo. mem_rw = 0. → WR0 if store, else RESP.
  - WR0: mem_addr = w0, mem_rw = 1, mem_wdata = lo with bytes off..min(off+size,4)-1 replaced by the low bytes of wdata. → WR1 if cross, else RESP.
  - WR1: mem_addr = w1, mem_rw = 1, mem_wdata = hi with bytes 0..(off+size-5) replaced by the remaining high bytes of wdata. → RESP.
  - RESP: resp_valid = 1 for exactly this cycle; req_ready = 0. → IDLE.
- Load extraction:
  - Form the 64-bit value {hi, lo} (hi = 0 if not cross) and shift it right by off*8.
  - Take the low size bytes, then sign-extend for b/h, zero-extend for bu/hu.
- Byte order: little-endian throughout.
- Latency, in cycles from the accept edge to resp_valid:
  - aligned sw: 2
  - non-crossing load: 3
  - crossing load: 4
  - non-crossing partial store: 4
  - crossing store: 6
- Back-to-back: a new request is accepted at the earliest in the cycle after RESP.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: any access that is not naturally aligned (h with addr[0] = 1, w with addr[1:0] ≠ 0) goes IDLE → RESP with resp_fault = 1, resp_rdata = 0 and no memory access. RD1 and WR1 become unreachable.
- Not defined: misaligned accesses are split as above, and resp_fault is asserted only for illegal funct3.

Test Plan:
- Reset then memory preload: word 0x100 = 0x8899AABB. lb at 0x101 → resp_rdata 0xFFFFFFAA at cycle 3; lbu at 0x101 → 0x000000AA.
- sb 0x5C to 0x102 over 0x8899AABB → exactly one write at 0x100 of 0x885CAABB; response at cycle 4; mem_rsel/mem_wsel stay 000/00 throughout.
- Words 0x200 = 0x44332211 and 0x204 = 0x88776655. lw at 0x203 → reads 0x200 then 0x204; resp_rdata = 0x77665544 at cycle 4 (macro undefined) or resp_fault = 1 with no memory access (macro defined).
- sh 0xBEEF to 0x1FF over words 0x1FC = 0, 0x200 = 0 → writes 0x1FC = 0xEF000000, then 0x200 = 0x000000BE; response at cycle 6.
- sw 0xCAFEF00D to 0x300 → a single write, no read, response at cycle 2. A load issued with funct3 = 011 → resp_fault = 1 with no memory access.
- Assert rst during WR0 of a crossing store → mem_rw = 0 that cycle; block returns to IDLE with req_ready = 1; no resp_valid pulse; word w1 unchanged.
